// File: rtl/ddr_cmd_timing_monitor.sv
// ddr_cmd_timing_monitor
//   Observes the DDR command stream, tracks per-bank open/closed state and
//   checks every issued command against the DRAM timing rules. A violating
//   command produces a one-cycle registered report on the cycle after it.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/cmd/cmd_bank  sampled command (ddr_cmd_t encoding)
//   stats_clr           synchronous clear of viol_count (wins over increment)
//   bank_open           per-bank open flags
//   viol_valid/mask/code/bank  report for the previous cycle's command
//   viol_count          saturating count of violating commands
module ddr_cmd_timing_monitor #(
    parameter int NUM_BANKS = 8,
    parameter int CW        = 8,
    parameter int T_RCD     = 18,
    parameter int T_RP      = 18,
    parameter int T_RAS     = 42,
    parameter int T_RRD     = 8,
    parameter int T_WR      = 15,
    parameter int T_RTP     = 8,
    parameter int T_WTR     = 8,
    parameter int T_CCD     = 4,
    parameter int T_FAW     = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    input  logic [3:0]                   cmd,
    input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
    input  logic                         stats_clr,
    output logic [NUM_BANKS-1:0]         bank_open,
    output logic                         viol_valid,
    output logic [8:0]                   viol_mask,
    output logic [3:0]                   viol_code,
    output logic [$clog2(NUM_BANKS)-1:0] viol_bank,
    output logic [15:0]                  viol_count
);
    localparam int BW = $clog2(NUM_BANKS);

    typedef enum logic [3:0] {
        CMD_MRS  = 4'b0000,
        CMD_REF  = 4'b0001,
        CMD_PRE  = 4'b0010,
        CMD_ACT  = 4'b0011,
        CMD_WR   = 4'b0100,
        CMD_RD   = 4'b0101,
        CMD_NOP  = 4'b0111,
        CMD_DES  = 4'b1000,
        CMD_PREA = 4'b1010
    } ddr_cmd_t;

    localparam logic [CW-1:0] AGE_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] AGE_ONE = CW'(1);
    localparam logic [CW-1:0] TA_RCD  = CW'(T_RCD);
    localparam logic [CW-1:0] TA_RP   = CW'(T_RP);
    localparam logic [CW-1:0] TA_RAS  = CW'(T_RAS);
    localparam logic [CW-1:0] TA_RRD  = CW'(T_RRD);
    localparam logic [CW-1:0] TA_WR   = CW'(T_WR);
    localparam logic [CW-1:0] TA_RTP  = CW'(T_RTP);
    localparam logic [CW-1:0] TA_WTR  = CW'(T_WTR);
    localparam logic [CW-1:0] TA_CCD  = CW'(T_CCD);
    localparam logic [CW-1:0] TA_FAW  = CW'(T_FAW);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] a);
        return (a == AGE_MAX) ? a : a + AGE_ONE;
    endfunction

    logic [CW-1:0] act_age_q [NUM_BANKS], act_age_d [NUM_BANKS];
    logic [CW-1:0] pre_age_q [NUM_BANKS], pre_age_d [NUM_BANKS];
    logic [CW-1:0] wr_age_q  [NUM_BANKS], wr_age_d  [NUM_BANKS];
    logic [CW-1:0] rd_age_q  [NUM_BANKS], rd_age_d  [NUM_BANKS];
    logic [CW-1:0] faw_age_q [4],         faw_age_d [4];
    logic [CW-1:0] last_act_q, last_act_d, last_col_q, last_col_d, last_wr_q, last_wr_d;
    logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
    logic          viol_valid_q, viol_valid_d;
    logic [8:0]    viol_mask_q, viol_mask_d;
    logic [3:0]    viol_code_q, viol_code_d;
    logic [BW-1:0] viol_bank_q, viol_bank_d;
    logic [15:0]   viol_count_q, viol_count_d;

    logic          is_act_s, is_rd_s, is_wr_s, is_pre_s, is_prea_s;
    logic [8:0]    mask_s;
    logic [BW-1:0] bank_s;
    logic [2:0]    bits_s;
    logic          found_s;

    assign is_act_s  = cmd_valid && (cmd == CMD_ACT);
    assign is_rd_s   = cmd_valid && (cmd == CMD_RD);
    assign is_wr_s   = cmd_valid && (cmd == CMD_WR);
    assign is_pre_s  = cmd_valid && (cmd == CMD_PRE);
    assign is_prea_s = cmd_valid && (cmd == CMD_PREA);

    // Rule checks of the current command against the ages left by earlier commands.
    always_comb begin
        mask_s  = 9'd0;
        bank_s  = cmd_bank;
        bits_s  = 3'd0;
        found_s = 1'b0;
        if (cmd_valid) begin
            case (cmd)
                CMD_ACT: begin
                    mask_s[0] = faw_age_q[3] < TA_FAW;
                    mask_s[2] = pre_age_q[cmd_bank] < TA_RP;
                    mask_s[4] = last_act_q < TA_RRD;
                    mask_s[8] = bank_open_q[cmd_bank];
                end
                CMD_RD: begin
                    mask_s[1] = act_age_q[cmd_bank] < TA_RCD;
                    mask_s[7] = last_wr_q < TA_WTR;
                    // tCCD has no code of its own and reports as ILLEGAL
                    mask_s[8] = (last_col_q < TA_CCD) | ~bank_open_q[cmd_bank];
                end
                CMD_WR: begin
                    mask_s[1] = act_age_q[cmd_bank] < TA_RCD;
                    mask_s[8] = (last_col_q < TA_CCD) | ~bank_open_q[cmd_bank];
                end
                CMD_PRE: begin
                    mask_s[3] = act_age_q[cmd_bank] < TA_RAS;
                    mask_s[5] = wr_age_q[cmd_bank]  < TA_WR;
                    mask_s[6] = rd_age_q[cmd_bank]  < TA_RTP;
                end
                CMD_PREA: begin
                    // Only open banks are checked; the first offender names the bank.
                    for (int i = 0; i < NUM_BANKS; i++) begin
                        bits_s = {rd_age_q[i] < TA_RTP, wr_age_q[i] < TA_WR,
                                  act_age_q[i] < TA_RAS} & {3{bank_open_q[i]}};
                        mask_s[3] = mask_s[3] | bits_s[0];
                        mask_s[5] = mask_s[5] | bits_s[1];
                        mask_s[6] = mask_s[6] | bits_s[2];
                        bank_s    = ((|bits_s) && !found_s) ? BW'(i) : bank_s;
                        found_s   = found_s | (|bits_s);
                    end
                end
                CMD_REF, CMD_MRS: mask_s[8] = |bank_open_q;
                CMD_NOP, CMD_DES: mask_s = 9'd0;
                default:          mask_s[8] = 1'b1;
            endcase
        end else begin
            mask_s = 9'd0;
        end
    end

    // Report encoding and saturating violation counter.
    always_comb begin
        viol_valid_d = |mask_s;
        viol_mask_d  = mask_s;
        viol_code_d  = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            viol_code_d = mask_s[i] ? 4'(i) : viol_code_d;
        end
        viol_bank_d  = viol_valid_d ? bank_s : {BW{1'b0}};
        viol_count_d = stats_clr ? 16'd0 :
                       (viol_valid_d && (viol_count_q != 16'hFFFF)) ? viol_count_q + 16'd1 :
                       viol_count_q;
    end

    // Age and bank-state next values; state changes apply even on violation.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            act_age_d[i] = (is_act_s && (cmd_bank == BW'(i))) ? AGE_ONE : sat_inc(act_age_q[i]);
            pre_age_d[i] = ((is_pre_s && (cmd_bank == BW'(i))) || is_prea_s) ?
                           AGE_ONE : sat_inc(pre_age_q[i]);
            // Column commands to a closed bank only touch the global ages
            wr_age_d[i]  = (is_wr_s && (cmd_bank == BW'(i)) && bank_open_q[i]) ?
                           AGE_ONE : sat_inc(wr_age_q[i]);
            rd_age_d[i]  = (is_rd_s && (cmd_bank == BW'(i)) && bank_open_q[i]) ?
                           AGE_ONE : sat_inc(rd_age_q[i]);
            bank_open_d[i] = (is_act_s && (cmd_bank == BW'(i))) ? 1'b1 :
                             (((is_pre_s && (cmd_bank == BW'(i))) || is_prea_s) ? 1'b0 :
                              bank_open_q[i]);
        end
        last_act_d = is_act_s ? AGE_ONE : sat_inc(last_act_q);
        last_col_d = (is_rd_s || is_wr_s) ? AGE_ONE : sat_inc(last_col_q);
        last_wr_d  = is_wr_s ? AGE_ONE : sat_inc(last_wr_q);
        // Four-deep ACT history: a new ACT shifts the older ages down one slot
        faw_age_d[0] = is_act_s ? AGE_ONE : sat_inc(faw_age_q[0]);
        for (int k = 1; k < 4; k++) begin
            faw_age_d[k] = is_act_s ? sat_inc(faw_age_q[k-1]) : sat_inc(faw_age_q[k]);
        end
    end

    // State and report registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                act_age_q[i] <= AGE_MAX;
                pre_age_q[i] <= AGE_MAX;
                wr_age_q[i]  <= AGE_MAX;
                rd_age_q[i]  <= AGE_MAX;
            end
            for (int k = 0; k < 4; k++) begin
                faw_age_q[k] <= AGE_MAX;
            end
            last_act_q   <= AGE_MAX;
            last_col_q   <= AGE_MAX;
            last_wr_q    <= AGE_MAX;
            bank_open_q  <= {NUM_BANKS{1'b0}};
            viol_valid_q <= 1'b0;
            viol_mask_q  <= 9'd0;
            viol_code_q  <= 4'd0;
            viol_bank_q  <= {BW{1'b0}};
            viol_count_q <= 16'd0;
        end else begin
            act_age_q    <= act_age_d;
            pre_age_q    <= pre_age_d;
            wr_age_q     <= wr_age_d;
            rd_age_q     <= rd_age_d;
            faw_age_q    <= faw_age_d;
            last_act_q   <= last_act_d;
            last_col_q   <= last_col_d;
            last_wr_q    <= last_wr_d;
            bank_open_q  <= bank_open_d;
            viol_valid_q <= viol_valid_d;
            viol_mask_q  <= viol_mask_d;
            viol_code_q  <= viol_code_d;
            viol_bank_q  <= viol_bank_d;
            viol_count_q <= viol_count_d;
        end
    end

    assign bank_open  = bank_open_q;
    assign viol_valid = viol_valid_q;
    assign viol_mask  = viol_mask_q;
    assign viol_code  = viol_code_q;
    assign viol_bank  = viol_bank_q;
    assign viol_count = viol_count_q;
endmodule

// File: tb/tb_ddr_cmd_timing_monitor.sv
module tb_ddr_cmd_timing_monitor;
    localparam int T_RCD = 18, T_RP = 18, T_RAS = 42, T_RRD = 8, T_WR = 15;
    localparam int T_RTP = 8, T_WTR = 8, T_CCD = 4, T_FAW = 40;
    localparam int NEVER = -1000000;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, PREA = 4'b1010, REF = 4'b0001, MRS = 4'b0000;
    localparam logic [3:0] DES = 4'b1000, BAD = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd = 4'b0111;
    logic [2:0]  cmd_bank = 3'd0;
    logic        stats_clr = 1'b0;
    logic [7:0]  bank_open;
    logic        viol_valid;
    logic [8:0]  viol_mask;
    logic [3:0]  viol_code;
    logic [2:0]  viol_bank;
    logic [15:0] viol_count;

    int checks = 0;
    int errors = 0;

    // reference model: event timestamps in cycles, ages are plain differences
    int cyc;
    int act_t[8], pre_t[8], wr_t[8], rd_t[8];
    int last_act, last_col, last_wr;
    int act_hist[$];
    logic [7:0]  m_open;
    logic [8:0]  exp_mask;
    logic [3:0]  exp_code;
    logic [2:0]  exp_bank;
    logic [15:0] exp_count;

    ddr_cmd_timing_monitor dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
        .stats_clr(stats_clr), .bank_open(bank_open), .viol_valid(viol_valid),
        .viol_mask(viol_mask), .viol_code(viol_code), .viol_bank(viol_bank),
        .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            act_t[i] = NEVER; pre_t[i] = NEVER; wr_t[i] = NEVER; rd_t[i] = NEVER;
        end
        last_act = NEVER; last_col = NEVER; last_wr = NEVER;
        act_hist.delete();
        m_open = 8'd0; exp_mask = 9'd0; exp_code = 4'd0; exp_bank = 3'd0; exp_count = 16'd0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] c, input logic [2:0] b, input bit clr);
        logic [8:0] m;
        logic [2:0] eb;
        bit found;
        m = 9'd0; eb = b; found = 1'b0;
        if (v) begin
            case (c)
                ACT: begin
                    m[2] = (cyc - pre_t[b]) < T_RP;
                    m[4] = (cyc - last_act) < T_RRD;
                    if (act_hist.size() >= 4) m[0] = (cyc - act_hist[act_hist.size() - 4]) < T_FAW;
                    m[8] = m_open[b];
                    act_t[b] = cyc; m_open[b] = 1'b1; last_act = cyc;
                    act_hist.push_back(cyc);
                    if (act_hist.size() > 4) void'(act_hist.pop_front());
                end
                RD: begin
                    m[1] = (cyc - act_t[b]) < T_RCD;
                    m[7] = (cyc - last_wr) < T_WTR;
                    m[8] = ((cyc - last_col) < T_CCD) || !m_open[b];
                    last_col = cyc;
                    if (m_open[b]) rd_t[b] = cyc;
                end
                WR: begin
                    m[1] = (cyc - act_t[b]) < T_RCD;
                    m[8] = ((cyc - last_col) < T_CCD) || !m_open[b];
                    last_col = cyc; last_wr = cyc;
                    if (m_open[b]) wr_t[b] = cyc;
                end
                PRE: begin
                    m[3] = (cyc - act_t[b]) < T_RAS;
                    m[5] = (cyc - wr_t[b]) < T_WR;
                    m[6] = (cyc - rd_t[b]) < T_RTP;
                    pre_t[b] = cyc; m_open[b] = 1'b0;
                end
                PREA: begin
                    for (int i = 0; i < 8; i++) begin
                        if (m_open[i]) begin
                            bit r, w, a;
                            a = (cyc - act_t[i]) < T_RAS;
                            w = (cyc - wr_t[i]) < T_WR;
                            r = (cyc - rd_t[i]) < T_RTP;
                            m[3] |= a; m[5] |= w; m[6] |= r;
                            if ((a || w || r) && !found) begin eb = 3'(i); found = 1'b1; end
                        end
                        pre_t[i] = cyc;
                    end
                    m_open = 8'd0;
                end
                REF, MRS: m[8] = (m_open != 8'd0);
                NOP, DES: m = 9'd0;
                default: m[8] = 1'b1;
            endcase
        end
        exp_mask = m;
        exp_bank = eb;
        exp_code = 4'd0;
        for (int i = 0; i < 9; i++) if (m[i]) begin exp_code = 4'(i); break; end
        if (clr) exp_count = 16'd0;
        else if (m != 9'd0 && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    endtask

    // drive one command at a falling edge, step the model, return at the next falling edge
    task automatic issue(input bit v, input logic [3:0] c, input logic [2:0] b, input bit clr);
        cmd_valid = v; cmd = c; cmd_bank = b; stats_clr = clr;
        model_step(v, c, b, clr);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd = NOP; stats_clr = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, NOP, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; stats_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bank_open, viol_valid, viol_mask, viol_code, viol_bank, viol_count} !== 41'd0) begin
            errors++;
            $display("FAIL reset_state: open=%h valid=%b mask=%h code=%0d bank=%0d count=%0d, want all 0",
                     bank_open, viol_valid, viol_mask, viol_code, viol_bank, viol_count);
        end
    endtask

    task automatic test_act_rd_ok();
        do_reset();
        issue(1'b1, ACT, 3'd0, 1'b0);
        idle(17);
        issue(1'b1, RD, 3'd0, 1'b0);
        checks++;
        if (viol_valid !== 1'b0 || bank_open !== 8'h01) begin
            errors++;
            $display("FAIL act_rd_ok: valid=%b open=%h, want valid=0 open=01", viol_valid, bank_open);
        end
    endtask

    task automatic test_trcd();
        do_reset();
        issue(1'b1, ACT, 3'd1, 1'b0);
        idle(9);
        issue(1'b1, WR, 3'd1, 1'b0);
        checks++;
        if (viol_valid !== 1'b1 || viol_mask !== 9'h002 || viol_code !== 4'd1 ||
            viol_bank !== 3'd1 || viol_count !== 16'd1) begin
            errors++;
            $display("FAIL trcd: valid=%b mask=%h code=%0d bank=%0d count=%0d, want 1 002 1 1 1",
                     viol_valid, viol_mask, viol_code, viol_bank, viol_count);
        end
        @(negedge clk);
        checks++;
        if (viol_valid !== 1'b0) begin
            errors++;
            $display("FAIL trcd_pulse: valid=%b, want 0 one cycle later", viol_valid);
        end
        cyc++;
    endtask

    task automatic test_tfaw(input int gap5, input logic [8:0] want);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, ACT, 3'(i), 1'b0);
            checks++;
            if (viol_valid !== 1'b0) begin
                errors++;
                $display("FAIL tfaw_setup: act %0d valid=%b, want 0", i, viol_valid);
            end
            idle(7);
        end
        idle(gap5 - 32);
        issue(1'b1, ACT, 3'd4, 1'b0);
        checks++;
        if (viol_mask !== want || viol_valid !== (want != 9'd0) ||
            (want != 9'd0 && (viol_code !== 4'd0 || viol_bank !== 3'd4))) begin
            errors++;
            $display("FAIL tfaw_t%0d: mask=%h valid=%b code=%0d bank=%0d, want mask %h",
                     gap5, viol_mask, viol_valid, viol_code, viol_bank, want);
        end
    endtask

    task automatic test_pre_timing();
        do_reset();
        issue(1'b1, ACT, 3'd2, 1'b0);
        idle(17);
        issue(1'b1, WR, 3'd2, 1'b0);
        checks++;
        if (viol_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_wr: valid=%b mask=%h, want 0", viol_valid, viol_mask);
        end
        idle(11);
        issue(1'b1, PRE, 3'd2, 1'b0);
        checks++;
        if (viol_mask !== 9'h028 || viol_code !== 4'd3 || viol_bank !== 3'd2 || bank_open[2] !== 1'b0) begin
            errors++;
            $display("FAIL pre_tras_twr: mask=%h code=%0d bank=%0d open=%h, want 028 3 2 open[2]=0",
                     viol_mask, viol_code, viol_bank, bank_open);
        end
    endtask

    task automatic test_illegal_and_clear();
        do_reset();
        issue(1'b1, RD, 3'd5, 1'b0);
        checks++;
        if (viol_mask !== 9'h100 || viol_code !== 4'd8 || viol_bank !== 3'd5 || bank_open !== 8'h00) begin
            errors++;
            $display("FAIL rd_closed: mask=%h code=%0d bank=%0d open=%h, want 100 8 5 00",
                     viol_mask, viol_code, viol_bank, bank_open);
        end
        issue(1'b1, ACT, 3'd0, 1'b0);
        issue(1'b1, REF, 3'd0, 1'b0);
        checks++;
        if (viol_valid !== 1'b1 || viol_code !== 4'd8 || viol_count !== 16'd2) begin
            errors++;
            $display("FAIL ref_open: valid=%b code=%0d count=%0d, want 1 8 2", viol_valid, viol_code, viol_count);
        end
        issue(1'b1, MRS, 3'd0, 1'b1);
        checks++;
        if (viol_valid !== 1'b1 || viol_count !== 16'd0) begin
            errors++;
            $display("FAIL clr_wins: valid=%b count=%0d, want 1 0", viol_valid, viol_count);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 65534; i++) issue(1'b1, BAD, 3'd0, 1'b0);
        checks++;
        if (viol_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL count_fffe: count=%h, want fffe", viol_count);
        end
        issue(1'b1, BAD, 3'd0, 1'b0);
        issue(1'b1, BAD, 3'd3, 1'b0);
        checks++;
        if (viol_count !== 16'hFFFF || viol_valid !== 1'b1 || viol_bank !== 3'd3) begin
            errors++;
            $display("FAIL count_sat: count=%h valid=%b bank=%0d, want ffff 1 3", viol_count, viol_valid, viol_bank);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        issue(1'b1, ACT, 3'd0, 1'b0);
        issue(1'b1, ACT, 3'd1, 1'b0);
        cmd_valid = 1'b1; cmd = RD; cmd_bank = 3'd6;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bank_open, viol_valid, viol_mask, viol_code, viol_bank, viol_count} !== 41'd0) begin
            errors++;
            $display("FAIL async_reset: open=%h valid=%b mask=%h count=%0d, want all 0",
                     bank_open, viol_valid, viol_mask, viol_count);
        end
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        model_reset();
        checks++;
        if (viol_valid !== 1'b0 || viol_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_no_pending: valid=%b count=%0d, want 0 0", viol_valid, viol_count);
        end
        issue(1'b1, ACT, 3'd0, 1'b0);
        checks++;
        if (viol_valid !== 1'b0 || bank_open !== 8'h01) begin
            errors++;
            $display("FAIL act_after_reset: valid=%b open=%h, want 0 01", viol_valid, bank_open);
        end
    endtask

    task automatic test_random();
        logic [3:0] pool [11];
        pool = '{ACT, ACT, RD, WR, PRE, PREA, REF, MRS, NOP, DES, 4'b1100};
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit v, clr;
            v   = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 199) == 0);
            issue(v, pool[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), clr);
            checks++;
            if (viol_valid !== (exp_mask != 9'd0) || viol_mask !== exp_mask || viol_count !== exp_count ||
                bank_open !== m_open ||
                (exp_mask != 9'd0 && (viol_code !== exp_code || viol_bank !== exp_bank))) begin
                errors++;
                $display("FAIL random cyc %0d: valid=%b mask=%h code=%0d bank=%0d count=%0d open=%h, want mask=%h code=%0d bank=%0d count=%0d open=%h",
                         cyc, viol_valid, viol_mask, viol_code, viol_bank, viol_count, bank_open,
                         exp_mask, exp_code, exp_bank, exp_count, m_open);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_act_rd_ok();
        test_trcd();
        test_tfaw(32, 9'h001);
        test_tfaw(40, 9'h000);
        test_pre_timing();
        test_illegal_and_clear();
        test_midstream_reset();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_cmd_timing_monitor.md
Name: ddr_cmd_timing_monitor

Overview:
- Memory-side observer and responder for the controller's DDR command stream.
- Samples every issued command and tracks per-bank open/closed state.
- Checks the issued commands against the package timing parameters (tFAW, tRCD, tRP, tRAS, tRRD, tWR, tRTP, tWTR, tCCD) and flags protocol-illegal commands.
- Sits beside the DFI command port in simulation and emulation builds.
- Reports violations with the package violation codes 0..7, plus code 8 for ILLEGAL.

Parameters:
- NUM_BANKS, 8, number of banks tracked (bank field width is $clog2(NUM_BANKS)).
- CW, 8, age-counter width; every age saturates at 2^CW-1.
- T_RCD, 18, minimum cycles from ACT to RD/WR, same bank.
- T_RP, 18, minimum cycles from PRE/PREA to ACT, same bank.
- T_RAS, 42, minimum cycles from ACT to PRE, same bank.
- T_RRD, 8, minimum cycles from ACT to ACT, any bank.
- T_WR, 15, minimum cycles from WR to PRE, same bank.
- T_RTP, 8, minimum cycles from RD to PRE, same bank.
- T_WTR, 8, minimum cycles from WR (any bank) to RD.
- T_CCD, 4, minimum cycles from RD/WR to RD/WR, any bank.
- T_FAW, 40, window that may contain at most four ACTs.

Ports:
- clk  in  1  controller clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is issued this cycle.
- cmd  in  4  command code in ddr_cmd_t encoding (NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, PREA 1010, REF 0001, MRS 0000, DES 1000).
- cmd_bank  in  $clog2(NUM_BANKS)  target bank; ignored for PREA, REF, MRS, NOP and DES.
- stats_clr  in  1  synchronous clear of viol_count.
- bank_open  out  NUM_BANKS  per-bank open flag.
- viol_valid  out  1  one-cycle pulse: the command sampled in the previous cycle violated at least one rule.
- viol_mask  out  9  bit i set means violation code i fired (0 tFAW, 1 tRCD, 2 tRP, 3 tRAS, 4 tRRD, 5 tWR, 6 tRTP, 7 tWTR, 8 ILLEGAL).
- viol_code  out  4  index of the lowest set bit in viol_mask.
- viol_bank  out  $clog2(NUM_BANKS)  cmd_bank of the offending command.
- viol_count  out  16  number of commands with at least one violation; saturates at 0xFFFF.

Behaviour:
- Reset values: bank_open=0, viol_valid=0, viol_mask=0, viol_code=0, viol_bank=0, viol_count=0. All age counters reset to 2^CW-1, so the first commands after reset never violate timing.
- Reset asserted mid-operation clears everything immediately; no pending report survives reset.
- Age semantics:
  - Each tracked event has an age register. It loads 1 at the edge that samples the event and then increments each cycle, saturating at 2^CW-1.
  - A command at cycle t sees age = t - t_event.
  - A check fires when age < T_x.
- Per-bank ages:
  - act_age: set by ACT.
  - pre_age: set by PRE, or by PREA for all banks.
  - wr_age: set by WR.
  - rd_age: set by RD.
- Global ages:
  - last_act_age: set by any ACT.
  - last_col_age: set by any RD or WR.
  - last_wr_age: set by any WR.
  - faw_age[0..3]: the last four ACTs, kept as a shift register. A new ACT shifts in age 1.
- Checks per command (evaluated only when cmd_valid=1):
  - ACT: tRP on pre_age[b]; tRRD on last_act_age; tFAW if faw_age[3] < T_FAW; ILLEGAL if bank b is already open.
  - RD: tRCD on act_age[b]; tCCD on last_col_age; tWTR on last_wr_age; ILLEGAL if bank b is closed.
  - WR: tRCD on act_age[b]; tCCD on last_col_age; ILLEGAL if bank b is closed.
  - tCCD has no package code. A tCCD failure sets the ILLEGAL bit (8).
  - PRE: tRAS on act_age[b]; tWR on wr_age[b]; tRTP on rd_age[b]. No ILLEGAL check: PRE to a closed bank is a legal no-op.
  - PREA: the PRE checks are applied to every open bank. viol_bank reports the lowest-numbered offending bank.
  - REF and MRS: ILLEGAL if any bank is open.
  - NOP and DES: no checks and no state change.
  - Any undefined cmd encoding: ILLEGAL, no state change.
- State update is applied even when a violation fires:
  - ACT sets bank_open[b].
  - PRE clears bank_open[b]; PREA clears all.
  - RD/WR to a closed bank update the global ages but not bank state.
- Latency: bank_open updates at the edge after the command. viol_* are registered and appear the cycle after the command, lasting one cycle.
- Back-to-back commands on consecutive cycles are fully supported. Each command is checked against the state left by all earlier commands.
- viol_count increments by 1 per violating command, regardless of how many bits are set.
- stats_clr in the same cycle as an increment: the clear wins and the count becomes 0.

Test Plan:
- Reset, then ACT b0 at t=0 and RD b0 at t=18 -> no viol_valid; bank_open=0x01.
- ACT b1 at t=0, WR b1 at t=10 -> at t=11: viol_valid=1, viol_mask=0x002, viol_code=1, viol_bank=1, viol_count=1.
- ACT b0,b1,b2,b3 at t=0,8,16,24, then ACT b4 at t=32 -> viol_mask=0x001 (tFAW only, since tRRD is met); an ACT at t=40 instead -> no violation.
- ACT b2 at t=0, WR b2 at t=18, PRE b2 at t=30 -> viol_mask=0x028 (tRAS and tWR), viol_code=3; bank_open[2]=0 afterwards.
- RD b5 with all banks closed -> viol_mask=0x100, code 8; bank_open unchanged. Then REF with b0 open -> code 8, and viol_count reads 2.
- Force viol_count=0xFFFF, then issue a violating command -> count stays 0xFFFF. Assert rst mid-stream -> all outputs 0; ACT b0 in the next cycle -> no violation.
